// File: rtl/logic_axi4_stream_arbiter_pkg.sv
// Shared types and helpers for the packet-aware AXI4-Stream arbiter.
package logic_axi4_stream_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int unsigned next_index(
    input int unsigned idx,
    input int unsigned count
  );
    return (idx + 32'd1 >= count) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/logic_arbiter_round_robin.sv
// Combinational round-robin pick: first request at or above the pointer,
// wrapping to zero. The parent owns the pointer register.
module logic_arbiter_round_robin
  import logic_axi4_stream_arbiter_pkg::*;
#(
  parameter int RX_COUNT = 4,
  parameter int IDX_W    = (RX_COUNT > 1) ? $clog2(RX_COUNT) : 1
) (
  input  logic [RX_COUNT-1:0] i_req,
  input  logic [IDX_W-1:0]    i_ptr,
  output logic [RX_COUNT-1:0] o_grant,
  output logic [IDX_W-1:0]    o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = i_ptr;
    for (int k = 0; k < RX_COUNT; k++) begin
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
      w_cand = IDX_W'(next_index(32'(w_cand), RX_COUNT));
    end
  end

endmodule

// File: rtl/logic_axi4_stream_arbiter.sv
// Packet-aware round-robin AXI4-Stream arbiter with a registered output.
// A granted source keeps the grant until its tlast beat is accepted.
module logic_axi4_stream_arbiter
  import logic_axi4_stream_arbiter_pkg::*;
#(
  parameter int RX_COUNT    = 4,
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int USE_TKEEP   = 1,
  parameter int USE_TSTRB   = 1,
  parameter int USE_TLAST   = 1,
  localparam int TID_WIDTH  = (RX_COUNT > 1) ? $clog2(RX_COUNT) : 1,
  localparam int DW         = TDATA_BYTES * 8
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic [RX_COUNT-1:0]             rx_tvalid,
  input  logic [RX_COUNT-1:0]             rx_tlast,
  input  logic [RX_COUNT*DW-1:0]          rx_tdata,
  input  logic [RX_COUNT*TDATA_BYTES-1:0] rx_tstrb,
  input  logic [RX_COUNT*TDATA_BYTES-1:0] rx_tkeep,
  input  logic [RX_COUNT*TDEST_WIDTH-1:0] rx_tdest,
  input  logic [RX_COUNT*TUSER_WIDTH-1:0] rx_tuser,
  output logic [RX_COUNT-1:0]             rx_tready,
  output logic                            tx_tvalid,
  output logic                            tx_tlast,
  output logic [DW-1:0]                   tx_tdata,
  output logic [TDATA_BYTES-1:0]          tx_tstrb,
  output logic [TDATA_BYTES-1:0]          tx_tkeep,
  output logic [TDEST_WIDTH-1:0]          tx_tdest,
  output logic [TUSER_WIDTH-1:0]          tx_tuser,
  output logic [TID_WIDTH-1:0]            tx_tid,
  input  logic                            tx_tready
);

  state_t                  r_state;
  logic                    r_en;
  logic [TID_WIDTH-1:0]    r_ptr;
  logic [TID_WIDTH-1:0]    r_owner;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic [DW-1:0]           r_tdata;
  logic [TDATA_BYTES-1:0]  r_tstrb;
  logic [TDATA_BYTES-1:0]  r_tkeep;
  logic [TDEST_WIDTH-1:0]  r_tdest;
  logic [TUSER_WIDTH-1:0]  r_tuser;
  logic [TID_WIDTH-1:0]    r_tid;

  logic                    w_load;
  logic                    w_accept;
  logic                    w_last;
  logic [RX_COUNT-1:0]     w_rr_grant;
  logic [TID_WIDTH-1:0]    w_rr_idx;
  logic [RX_COUNT-1:0]     w_grant;
  logic [TID_WIDTH-1:0]    w_idx;
  logic [DW-1:0]           w_data;
  logic [TDATA_BYTES-1:0]  w_strb;
  logic [TDATA_BYTES-1:0]  w_keep;
  logic [TDEST_WIDTH-1:0]  w_dest;
  logic [TUSER_WIDTH-1:0]  w_user;

  logic_arbiter_round_robin #(
    .RX_COUNT (RX_COUNT),
    .IDX_W    (TID_WIDTH)
  ) u_rr (
    .i_req   (rx_tvalid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx)
  );

  assign w_load = ~r_tvalid | tx_tready;

  always_comb begin
    w_grant = w_rr_grant;
    w_idx   = w_rr_idx;
    if (r_state == LOCKED) begin
      w_grant          = '0;
      w_grant[r_owner] = 1'b1;
      w_idx            = r_owner;
    end
  end

  // r_en keeps every ready low while reset is held and on release.
  assign rx_tready = w_grant & {RX_COUNT{w_load & r_en}};
  assign w_accept  = |(rx_tvalid & rx_tready);

  assign w_last = (USE_TLAST != 0) ? rx_tlast[w_idx] : 1'b1;
  assign w_data = rx_tdata[int'(w_idx)*DW +: DW];
  assign w_strb = (USE_TSTRB != 0) ?
    rx_tstrb[int'(w_idx)*TDATA_BYTES +: TDATA_BYTES] : '1;
  assign w_keep = (USE_TKEEP != 0) ?
    rx_tkeep[int'(w_idx)*TDATA_BYTES +: TDATA_BYTES] : '1;
  assign w_dest = rx_tdest[int'(w_idx)*TDEST_WIDTH +: TDEST_WIDTH];
  assign w_user = rx_tuser[int'(w_idx)*TUSER_WIDTH +: TUSER_WIDTH];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state  <= IDLE;
      r_en     <= 1'b0;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
      r_tkeep  <= '0;
      r_tdest  <= '0;
      r_tuser  <= '0;
      r_tid    <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_load) begin
        r_tvalid <= w_accept;
      end
      if (w_accept) begin
        r_tlast <= w_last;
        r_tdata <= w_data;
        r_tstrb <= w_strb;
        r_tkeep <= w_keep;
        r_tdest <= w_dest;
        r_tuser <= w_user;
        r_tid   <= w_idx;
        if (w_last) begin
          r_state <= IDLE;
          r_ptr   <= TID_WIDTH'(next_index(32'(w_idx), RX_COUNT));
        end else begin
          r_state <= LOCKED;
          r_owner <= w_idx;
        end
      end
    end
  end

  assign tx_tvalid = r_tvalid;
  assign tx_tlast  = r_tlast;
  assign tx_tdata  = r_tdata;
  assign tx_tstrb  = r_tstrb;
  assign tx_tkeep  = r_tkeep;
  assign tx_tdest  = r_tdest;
  assign tx_tuser  = r_tuser;
  assign tx_tid    = r_tid;

endmodule

// File: tb/tb_logic_axi4_stream_arbiter.sv
// Bench for logic_axi4_stream_arbiter: random AXI sources and downstream
// readiness checked cycle by cycle against a transaction-level model.
module tb_logic_axi4_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic        last;
    logic        user;
    logic        dest;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  logic            aclk = 1'b0;
  logic            areset_n;
  logic [N-1:0]    rx_tvalid, rx_tlast, rx_tready;
  logic [N*DW-1:0] rx_tdata;
  logic [N*4-1:0]  rx_tstrb, rx_tkeep;
  logic [N-1:0]    rx_tdest, rx_tuser;
  logic            tx_tvalid, tx_tlast, tx_tready;
  logic [DW-1:0]   tx_tdata;
  logic [3:0]      tx_tstrb, tx_tkeep;
  logic            tx_tdest, tx_tuser;
  logic [1:0]      tx_tid;

  always #5 aclk = ~aclk;

  logic_axi4_stream_arbiter #(
    .RX_COUNT(N), .TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1),
    .USE_TKEEP(1), .USE_TSTRB(1), .USE_TLAST(1)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata),
    .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tdest(rx_tdest),
    .rx_tuser(rx_tuser), .rx_tready(rx_tready),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tdata(tx_tdata),
    .tx_tstrb(tx_tstrb), .tx_tkeep(tx_tkeep), .tx_tdest(tx_tdest),
    .tx_tuser(tx_tuser), .tx_tid(tx_tid), .tx_tready(tx_tready)
  );

  beat_t srcq [N][$];
  bit    pres [N];
  int    acc_cnt [N];
  int    gap_at [N];
  int    gap_left [N];
  int    pv;
  int    rdy_mode;

  bit         m_locked;
  int         m_owner, m_ptr, m_sel;
  bit         m_load;
  logic [N-1:0] m_ready;
  logic       e_tvalid;
  beat_t      e_beat;
  int         e_tid;

  int tid_log[$];
  int n_tests, n_fail;

  function automatic beat_t tx_obs();
    return {tx_tlast, tx_tuser, tx_tdest, tx_tkeep, tx_tstrb, tx_tdata};
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_sel = -1; m_ready = '0;
    e_tvalid = 1'b0; e_beat = '0; e_tid = 0;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      pres[i] = 0; acc_cnt[i] = 0; gap_at[i] = -1; gap_left[i] = 0;
    end
  endfunction

  // Which source may transfer this cycle, from the packet/round-robin rules.
  function automatic void model_comb();
    int win = -1;
    m_sel = -1;
    m_ready = '0;
    m_load = !e_tvalid || (tx_tready === 1'b1);
    if (!areset_n) return;
    if (m_locked) win = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (win < 0 && rx_tvalid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    if (win >= 0 && m_load) begin
      m_ready[win] = 1'b1;
      if (rx_tvalid[win]) m_sel = win;
    end
  endfunction

  function automatic void model_clk();
    if (!areset_n || !m_load) return;
    e_tvalid = (m_sel >= 0);
    if (m_sel < 0) return;
    e_beat = srcq[m_sel].pop_front();
    e_tid = m_sel;
    pres[m_sel] = 0;
    acc_cnt[m_sel]++;
    if (e_beat.last) begin
      m_locked = 0;
      m_ptr = (m_sel + 1) % N;
    end else begin
      m_locked = 1;
      m_owner = m_sel;
    end
  endfunction

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 0;
    return !e_tvalid;
  endfunction

  function automatic int count_tid(input int t);
    int n = 0;
    foreach (tid_log[k]) if (tid_log[k] == t) n++;
    return n;
  endfunction

  task automatic add_pkt(input int s, input int len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.data = $urandom;
      x.strb = 4'($urandom);
      x.keep = 4'($urandom);
      x.dest = 1'($urandom);
      x.user = 1'($urandom);
      x.last = (b == len - 1);
      srcq[s].push_back(x);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      beat_t b;
      if (!pres[i] && srcq[i].size() > 0) begin
        if (acc_cnt[i] == gap_at[i] && gap_left[i] > 0) gap_left[i]--;
        else if (int'($urandom_range(99)) < pv) pres[i] = 1;
      end
      b = pres[i] ? srcq[i][0] : {$urandom, 11'($urandom)};
      rx_tvalid[i] = pres[i];
      rx_tlast[i] = b.last;
      rx_tdata[i*DW +: DW] = b.data;
      rx_tstrb[i*4 +: 4] = b.strb;
      rx_tkeep[i*4 +: 4] = b.keep;
      rx_tdest[i] = b.dest;
      rx_tuser[i] = b.user;
    end
    case (rdy_mode)
      0: tx_tready = 1'b1;
      1: tx_tready = ~tx_tready;
      default: tx_tready = 1'($urandom);
    endcase
  endtask

  task automatic step();
    @(posedge aclk);
    model_clk();
    @(negedge aclk);
    drive();
    #1;
    model_comb();
    if (tx_tvalid === 1'b1 && tx_tready) tid_log.push_back(int'(tx_tid));
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset_n = 1'b0;
    model_reset();
    pv = 100;
    rdy_mode = 0;
    drive();
    @(negedge aclk);
    areset_n = 1'b1;
    drive();
    #1;
    model_comb();
    step();
    step();
    tid_log.delete();
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      rx_tvalid = 4'($urandom);
      rx_tlast = 4'($urandom);
      rx_tdata = {$urandom, $urandom, $urandom, $urandom};
      tx_tready = 1'($urandom);
      #1;
      n_tests++;
      if (rx_tready !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_ready: got %b want 0000", rx_tready);
      end
      n_tests++;
      if ({tx_tvalid, tx_tlast, tx_tdata, tx_tid} !== '0) begin
        n_fail++;
        $display("FAIL reset_tx: valid %b last %b data %h tid %0d want all 0",
                 tx_tvalid, tx_tlast, tx_tdata, tx_tid);
      end
    end
    @(negedge aclk);
    areset_n = 1'b1;
    pv = 100;
    rdy_mode = 0;
    drive();
    #1;
    model_comb();
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (rx_tready !== 4'b0 || tx_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset: ready %b valid %b want 0000/0",
                 rx_tready, tx_tvalid);
      end
    end
  endtask

  task automatic check_run(input string name, input int budget,
                           input int exp_tids[$]);
    int c;
    for (c = 0; c < budget && !drained(); c++) begin
      step();
      n_tests++;
      if (rx_tready !== m_ready) begin
        n_fail++;
        $display("FAIL %s_ready: got %b want %b", name, rx_tready, m_ready);
      end
      n_tests++;
      if (tx_tvalid !== e_tvalid) begin
        n_fail++;
        $display("FAIL %s_valid: got %b want %b", name, tx_tvalid, e_tvalid);
      end
      if (e_tvalid) begin
        n_tests++;
        if (tx_obs() !== e_beat || tx_tid !== 2'(e_tid)) begin
          n_fail++;
          $display("FAIL %s_beat: got %h tid %0d want %h tid %0d",
                   name, tx_obs(), tx_tid, e_beat, e_tid);
        end
      end
    end
    n_tests++;
    if (!drained()) begin
      n_fail++;
      $display("FAIL %s_timeout: not drained after %0d cycles", name, budget);
    end
    if (exp_tids.size() > 0) begin
      n_tests++;
      if (tid_log != exp_tids) begin
        n_fail++;
        $display("FAIL %s_order: got %p want %p", name, tid_log, exp_tids);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp[$];
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) begin
        add_pkt(i, 1);
        exp.push_back(i);
      end
    check_run("rr", 100, exp);
  endtask

  task automatic test_packet_lock();
    int exp[$] = '{1, 1, 1, 2, 2};
    do_reset();
    add_pkt(1, 3);
    add_pkt(2, 1);
    add_pkt(2, 1);
    check_run("lock", 100, exp);
  endtask

  task automatic test_backpressure();
    int exp[$] = '{0, 0, 0, 0, 0, 1, 1};
    do_reset();
    rdy_mode = 1;
    add_pkt(0, 5);
    add_pkt(1, 1);
    add_pkt(1, 1);
    check_run("bp", 100, exp);
  endtask

  task automatic test_gap();
    int exp[$] = '{0, 0, 0, 0, 3, 3};
    do_reset();
    add_pkt(0, 4);
    add_pkt(3, 1);
    add_pkt(3, 1);
    gap_at[0] = 2;
    gap_left[0] = 2;
    check_run("gap", 100, exp);
  endtask

  task automatic test_reset_mid();
    int none[$];
    int exp[$] = '{0, 3};
    do_reset();
    add_pkt(1, 1);
    check_run("mid_pre", 50, none);
    tid_log.delete();
    add_pkt(2, 4);
    for (int c = 0; c < 50 && count_tid(2) < 2; c++) step();
    n_tests++;
    if (count_tid(2) != 2) begin
      n_fail++;
      $display("FAIL mid_beats: got %0d src2 beats want 2", count_tid(2));
    end
    step();
    n_tests++;
    if (tx_tvalid !== 1'b1 || tx_tid !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_inflight: valid %b tid %0d want 1/2", tx_tvalid, tx_tid);
    end
    #2;
    areset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (tx_tvalid !== 1'b0 || rx_tready !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid %b ready %b want 0/0000", tx_tvalid, rx_tready);
    end
    @(negedge aclk);
    drive();
    @(negedge aclk);
    areset_n = 1'b1;
    drive();
    #1;
    model_comb();
    step();
    step();
    tid_log.delete();
    add_pkt(0, 1);
    add_pkt(3, 1);
    check_run("mid_post", 50, exp);
  endtask

  task automatic test_random();
    int none[$];
    int total = 0;
    do_reset();
    pv = 60;
    rdy_mode = 2;
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < N; i++) begin
        int len = int'($urandom_range(4, 1));
        add_pkt(i, len);
        total += len;
      end
    check_run("rand", 3000, none);
    n_tests++;
    if (tid_log.size() != total) begin
      n_fail++;
      $display("FAIL rand_count: got %0d beats want %0d", tid_log.size(), total);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    tx_tready = 1'b1;
    pv = 0;
    rdy_mode = 0;
    rx_tvalid = '0;
    rx_tlast = '0;
    rx_tdata = '0;
    rx_tstrb = '0;
    rx_tkeep = '0;
    rx_tdest = '0;
    rx_tuser = '0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
